// File: rtl/song_recorder.sv
// Records a held-key melody into beat-quantised song entries: voice one gets the
// note, voices two and three get rests of the same duration, ending with a terminator.
module song_recorder #(
    parameter int IDX_WIDTH = 7,
    parameter int MAX_DUR   = 63
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 record_button,
    input  logic [1:0]           song,
    input  logic                 beat,
    input  logic                 key_valid,
    input  logic [5:0]           key_note,
    output logic                 wr_en,
    output logic [IDX_WIDTH+1:0] wr_addr,
    output logic [35:0]          wr_data,
    output logic                 recording,
    output logic                 full
);

    typedef enum logic [1:0] {IDLE, ARMED, TRACK, TERM} state_t;

    localparam logic [IDX_WIDTH-1:0] IDX_ONE = 1;
    localparam logic [6:0]           DUR_MAX = 7'(MAX_DUR);

    state_t               state;
    logic [1:0]           song_l;
    logic [IDX_WIDTH-1:0] idx;
    logic [5:0]           count;
    logic [5:0]           seg_note;

    logic [5:0]  eff_note;
    logic [6:0]  cnt_next;
    logic [5:0]  dur_close;
    logic        saturate;
    logic        at_last;
    logic [35:0] close_data;

    // A beat landing on the closing cycle counts toward the segment being closed.
    always_comb begin
        eff_note   = (key_valid && key_note != '0) ? key_note : '0;
        cnt_next   = {1'b0, count} + {6'd0, beat};
        dur_close  = (cnt_next == '0) ? 6'd1 : cnt_next[5:0];
        saturate   = beat && (cnt_next == DUR_MAX);
        at_last    = (idx == '1);
        close_data = {seg_note, 12'd0, dur_close, dur_close, dur_close};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            song_l    <= '0;
            idx       <= '0;
            count     <= '0;
            seg_note  <= '0;
            full      <= 1'b0;
            recording <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    recording <= 1'b0;
                    if (record_button) begin
                        song_l    <= song;
                        idx       <= '0;
                        full      <= 1'b0;
                        recording <= 1'b1;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (record_button) begin
                        state <= TERM;
                    end else if (key_valid && key_note != '0) begin
                        seg_note <= key_note;
                        count    <= '0;
                        state    <= TRACK;
                    end
                end
                TRACK: begin
                    if (record_button) begin
                        // Trailing rests are dropped; a note still held is flushed.
                        if (seg_note != '0) begin
                            if (at_last) begin
                                full <= 1'b1;
                            end else begin
                                wr_en   <= 1'b1;
                                wr_addr <= {song_l, idx};
                                wr_data <= close_data;
                                idx     <= idx + IDX_ONE;
                            end
                        end
                        state <= TERM;
                    end else if (eff_note != seg_note || saturate) begin
                        if (at_last) begin
                            full  <= 1'b1;
                            state <= TERM;
                        end else begin
                            wr_en    <= 1'b1;
                            wr_addr  <= {song_l, idx};
                            wr_data  <= close_data;
                            idx      <= idx + IDX_ONE;
                            seg_note <= eff_note;
                            count    <= '0;
                        end
                    end else begin
                        count <= cnt_next[5:0];
                    end
                end
                TERM: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {song_l, idx};
                    wr_data <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
